// File: rtl/user_uart_pkg.sv
// Shared definitions for the Wishbone UART transmitter: register map,
// STATUS bit positions, transmit FSM states and the divisor floor.
package user_uart_pkg;

  localparam logic [3:0] REG_DATA   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_DIV    = 4'h8;
  localparam logic [3:0] REG_CTRL   = 4'hC;

  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 4;

  localparam logic [15:0] DIV_MIN = 16'd2;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Divisors below the floor would collapse a bit to zero or one clock.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/user_uart_fifo.sv
// Show-ahead synchronous FIFO: dout presents the head entry whenever not empty.
// A push while full is accepted only if a pop happens on the same edge.
module user_uart_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clock,
  input  logic             srst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/user_uart_tx.sv
// Wishbone-slave 8N1 UART transmitter with an 8-entry byte FIFO,
// programmable bit period and a drain-complete interrupt.
module user_uart_tx
  import user_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd4167
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        uart_tx_o,
  output logic        io_oeb_o,
  output logic        irq_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic        ack_reg;
  logic [31:0] dat_reg;
  logic [15:0] div_reg;
  logic        irq_en_reg;
  logic        ovf_reg;
  logic        irq_reg;

  tx_state_t   state_reg;
  logic [15:0] timer_reg;
  logic [15:0] div_lat_reg;
  logic [2:0]  idx_reg;
  logic [7:0]  shift_reg;
  logic        tx_reg;

  logic          wb_req;
  logic          wb_wr;
  logic [3:0]    wb_off;
  logic [31:0]   rdata;
  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          busy;
  logic          unused_bits;

  assign wb_off    = wbs_adr_i[3:0];
  assign wb_req    = wbs_stb_i & wbs_cyc_i & ~ack_reg &
                     (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wb_wr     = wb_req & wbs_we_i;
  assign fifo_push = wb_wr & (wb_off == REG_DATA) & wbs_sel_i[0];
  assign busy      = (state_reg != IDLE);
  // The last clock of a stop bit pops the next byte so frames run back to back.
  assign fifo_pop  = ~fifo_empty &
                     ((state_reg == IDLE) | ((state_reg == STOP) & (timer_reg == '0)));

  assign wbs_ack_o   = ack_reg;
  assign wbs_dat_o   = dat_reg;
  assign uart_tx_o   = tx_reg;
  assign irq_o       = irq_reg;
  assign io_oeb_o    = 1'b0;
  assign unused_bits = &{1'b0, wbs_dat_i[31:16], wbs_sel_i[3:2]};

  user_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock (wb_clk_i),
    .srst  (wb_rst_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wbs_dat_i[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    rdata = '0;
    case (wb_off)
      REG_STATUS: begin
        rdata[ST_BUSY]             = busy;
        rdata[ST_FULL]             = fifo_full;
        rdata[ST_EMPTY]            = fifo_empty;
        rdata[ST_OVF]              = ovf_reg;
        rdata[ST_COUNT_LSB +: 4]   = 4'(fifo_count);
      end
      REG_DIV:  rdata[15:0] = div_reg;
      REG_CTRL: rdata[0]    = irq_en_reg;
      default:  rdata       = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_reg    <= 1'b0;
      dat_reg    <= '0;
      div_reg    <= DIV_RESET;
      irq_en_reg <= 1'b0;
      ovf_reg    <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      ack_reg <= wb_req;
      if (wb_req) begin
        dat_reg <= wbs_we_i ? 32'd0 : rdata;
      end
      if (wb_wr && (wb_off == REG_DIV)) begin
        if (wbs_sel_i[0]) div_reg[7:0]  <= wbs_dat_i[7:0];
        if (wbs_sel_i[1]) div_reg[15:8] <= wbs_dat_i[15:8];
      end
      if (wb_wr && (wb_off == REG_CTRL) && wbs_sel_i[0]) begin
        irq_en_reg <= wbs_dat_i[0];
      end
      if (fifo_push && fifo_full && !fifo_pop) begin
        ovf_reg <= 1'b1;
      end else if (wb_wr && (wb_off == REG_STATUS) && wbs_sel_i[0] && wbs_dat_i[ST_OVF]) begin
        ovf_reg <= 1'b0;
      end
      irq_reg <= irq_en_reg & fifo_empty & ~busy;
    end
  end

  // Line level is registered from the current state, so the wire trails the FSM by one clock.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      div_lat_reg <= DIV_MIN;
      idx_reg     <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
    end else begin
      case (state_reg)
        START:   tx_reg <= 1'b0;
        DATA:    tx_reg <= shift_reg[0];
        default: tx_reg <= 1'b1;
      endcase

      case (state_reg)
        IDLE: begin
          if (fifo_pop) begin
            state_reg   <= START;
            shift_reg   <= fifo_dout;
            div_lat_reg <= eff_div(div_reg);
            timer_reg   <= eff_div(div_reg) - 16'd1;
          end
        end
        START: begin
          if (timer_reg == '0) begin
            state_reg <= DATA;
            idx_reg   <= '0;
            timer_reg <= div_lat_reg - 16'd1;
          end else begin
            timer_reg <= timer_reg - 16'd1;
          end
        end
        DATA: begin
          if (timer_reg == '0) begin
            timer_reg <= div_lat_reg - 16'd1;
            shift_reg <= {1'b0, shift_reg[7:1]};
            if (idx_reg == 3'd7) begin
              state_reg <= STOP;
            end else begin
              idx_reg <= idx_reg + 3'd1;
            end
          end else begin
            timer_reg <= timer_reg - 16'd1;
          end
        end
        STOP: begin
          if (timer_reg == '0) begin
            if (fifo_pop) begin
              state_reg   <= START;
              shift_reg   <= fifo_dout;
              div_lat_reg <= eff_div(div_reg);
              timer_reg   <= eff_div(div_reg) - 16'd1;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            timer_reg <= timer_reg - 16'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_user_uart_tx.sv
// Randomised scoreboard bench for user_uart_tx: a queue-level model predicts
// frames, register reads and irq; a monitor decodes the serial line.
module tb_user_uart_tx;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        wb_clk_i  = 1'b0;
  logic        wb_rst_i  = 1'b1;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_we_i  = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = '0;
  logic [31:0] wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        uart_tx_o;
  logic        io_oeb_o;
  logic        irq_o;

  user_uart_tx dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .uart_tx_o (uart_tx_o),
    .io_oeb_o  (io_oeb_o),
    .irq_o     (irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int errors = 0;
  int unsigned cyc_cnt = 0;
  logic rst_q = 1'b0;

  always @(posedge wb_clk_i) begin
    cyc_cnt <= cyc_cnt + 1;
    rst_q   <= wb_rst_i;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          kind;   // 0 push, 1 div, 2 ctrl, 3 status
    int unsigned edge_n;
    logic [31:0] val;
    logic [3:0]  sel;
  } ev_t;

  typedef struct {
    logic [7:0]  b;
    int unsigned d;
    int unsigned start;
  } fr_t;

  ev_t         ev_q[$];
  fr_t         exp_q[$];
  logic [7:0]  m_q[$];
  int unsigned m_tx_ready = 0;
  logic [15:0] m_div = 16'd4167;
  logic        m_irq_en = 1'b0;
  logic        m_ovf = 1'b0;

  function automatic logic [31:0] exp_status(input int unsigned r);
    logic [31:0] s;
    s = '0;
    s[0]   = (m_tx_ready > r - 1);
    s[1]   = (m_q.size() == 8);
    s[2]   = (m_q.size() == 0);
    s[3]   = m_ovf;
    s[7:4] = 4'(m_q.size());
    return s;
  endfunction

  // Model steps once per edge: irq from the prior state, then pop, then bus events.
  initial begin
    int unsigned t;
    int unsigned d;
    logic exp_irq;
    ev_t e;
    forever begin
      @(negedge wb_clk_i);
      t = cyc_cnt;
      if (t != 0) begin
        exp_irq = rst_q ? 1'b0 : (m_irq_en && (m_q.size() == 0) && !(m_tx_ready > t - 1));
        chk("irq_level", {31'd0, irq_o}, {31'd0, exp_irq});
        if (rst_q) begin
          m_q.delete();
          exp_q.delete();
          m_tx_ready = 0;
          m_div      = 16'd4167;
          m_irq_en   = 1'b0;
          m_ovf      = 1'b0;
          while (ev_q.size() > 0 && ev_q[0].edge_n <= t) void'(ev_q.pop_front());
        end else begin
          if (m_q.size() > 0 && m_tx_ready <= t) begin
            d = (m_div < 16'd2) ? 2 : int'(m_div);
            exp_q.push_back('{b: m_q.pop_front(), d: d, start: t + 1});
            m_tx_ready = t + 10 * d;
          end
          while (ev_q.size() > 0 && ev_q[0].edge_n <= t) begin
            e = ev_q.pop_front();
            case (e.kind)
              0: if (m_q.size() < 8) m_q.push_back(e.val[7:0]); else m_ovf = 1'b1;
              1: for (int b = 0; b < 2; b++) if (e.sel[b]) m_div[8*b +: 8] = e.val[8*b +: 8];
              2: if (e.sel[0]) m_irq_en = e.val[0];
              3: if (e.sel[0] && e.val[3]) m_ovf = 1'b0;
              default: ;
            endcase
          end
        end
      end
    end
  end

  // ---------------- serial monitor ----------------
  int   frames_seen = 0;
  logic mon_busy = 1'b0;
  int   mon_div_log[$];
  int unsigned mon_start_log[$];

  initial begin
    fr_t f;
    logic bad, aborted, expb;
    logic [7:0] got;
    int unsigned start;
    int bi;
    forever begin
      @(negedge wb_clk_i);
      if (!rst_q && cyc_cnt != 0 && uart_tx_o === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'd1, 32'd0);
          for (int g = 0; g < 2000 && uart_tx_o !== 1'b1; g++) @(negedge wb_clk_i);
        end else begin
          mon_busy = 1'b1;
          f = exp_q.pop_front();
          start = cyc_cnt;
          bad = 1'b0;
          aborted = 1'b0;
          got = '0;
          for (int i = 0; i < 10 * int'(f.d); i++) begin
            if (i > 0) @(negedge wb_clk_i);
            if (rst_q) begin
              aborted = 1'b1;
              break;
            end
            bi = i / int'(f.d);
            expb = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : f.b[bi-1];
            if (uart_tx_o !== expb) bad = 1'b1;
            if (bi >= 1 && bi <= 8 && (i % int'(f.d)) == int'(f.d) / 2) got[bi-1] = uart_tx_o;
          end
          if (!aborted) begin
            frames_seen++;
            mon_div_log.push_back(int'(f.d));
            mon_start_log.push_back(start);
            $display("frame %0d: byte=0x%02h div=%0d start=%0d", frames_seen, got, f.d, start);
            chk("frame_start_edge", start, f.start);
            chk("frame_bits", {23'd0, bad, got}, {23'd0, 1'b0, f.b});
          end
          mon_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- bus driver ----------------
  task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output logic [31:0] rdata,
                          output int unsigned edge_n, output logic acked);
    @(posedge wb_clk_i); #1;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    acked = 1'b0; rdata = '0; edge_n = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin
        acked = 1'b1; edge_n = cyc_cnt; rdata = wbs_dat_o;
        break;
      end
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    $display("wb %s adr=0x%08h dat=0x%08h sel=%b ack=%0d edge=%0d",
             we ? "wr" : "rd", adr, we ? dat : rdata, sel, acked, edge_n);
  endtask

  task automatic wb_write(input logic [3:0] off, input logic [31:0] dat, input logic [3:0] sel,
                          output int unsigned edge_n);
    logic [31:0] rd;
    logic acked;
    wb_cycle(1'b1, BASE + {28'd0, off}, dat, sel, rd, edge_n, acked);
    chk("write_ack", {31'd0, acked}, 32'd1);
    if (acked) begin
      case (off)
        4'h0: if (sel[0]) ev_q.push_back('{kind: 0, edge_n: edge_n, val: dat, sel: sel});
        4'h4: ev_q.push_back('{kind: 3, edge_n: edge_n, val: dat, sel: sel});
        4'h8: ev_q.push_back('{kind: 1, edge_n: edge_n, val: dat, sel: sel});
        4'hC: ev_q.push_back('{kind: 2, edge_n: edge_n, val: dat, sel: sel});
        default: ;
      endcase
    end
  endtask

  task automatic wb_read(input logic [3:0] off, output logic [31:0] rd, output int unsigned edge_n);
    logic acked;
    wb_cycle(1'b0, BASE + {28'd0, off}, 32'd0, 4'hF, rd, edge_n, acked);
    chk("read_ack", {31'd0, acked}, 32'd1);
  endtask

  task automatic read_status_model(input string name);
    logic [31:0] rd;
    int unsigned r;
    wb_read(4'h4, rd, r);
    chk(name, rd, exp_status(r));
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (!(m_q.size() == 0 && m_tx_ready <= cyc_cnt && exp_q.size() == 0 && !mon_busy)
           && n < budget) begin
      @(posedge wb_clk_i); #1;
      n++;
    end
    if (n >= budget) chk("drain_timeout", 32'd1, 32'd0);
    repeat (3) @(posedge wb_clk_i);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    int unsigned e, e2, fall, rise;
    int base_frames;
    logic acked, seen0;

    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;
    chk("rst_tx", {31'd0, uart_tx_o}, 32'd1);
    chk("rst_irq", {31'd0, irq_o}, 32'd0);
    chk("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
    chk("rst_dat", wbs_dat_o, 32'd0);
    chk("oeb", {31'd0, io_oeb_o}, 32'd0);

    wb_read(4'h4, rd, e); chk("rst_status", rd, 32'h4);
    @(posedge wb_clk_i); #1;
    chk("ack_one_cycle", {31'd0, wbs_ack_o}, 32'd0);
    wb_read(4'h8, rd, e); chk("rst_div", rd, 32'd4167);
    wb_read(4'hC, rd, e); chk("rst_ctrl", rd, 32'd0);
    wb_read(4'h0, rd, e); chk("data_reads_zero", rd, 32'd0);
    wb_read(4'h1, rd, e); chk("unmapped_zero", rd, 32'd0);
    wb_cycle(1'b0, BASE + 32'h10, 32'd0, 4'hF, rd, e, acked);
    chk("outside_no_ack", {31'd0, acked}, 32'd0);
    wb_write(4'h8, 32'h0000_1234, 4'b0010, e);
    wb_read(4'h8, rd, e); chk("div_bytesel", rd, 32'h0000_1247);

    // single frame, latency from the push edge
    wb_write(4'h8, 32'd4, 4'hF, e);
    wb_write(4'h0, 32'hA5, 4'hF, e);
    fall = 0;
    for (int i = 0; i < 20; i++) begin
      if (uart_tx_o === 1'b0) begin
        fall = cyc_cnt;
        break;
      end
      @(posedge wb_clk_i); #1;
    end
    chk("a5_latency", fall, e + 2);
    read_status_model("a5_status_busy");
    wait_drain(200);
    read_status_model("a5_status_idle");

    // three back-to-back frames at the minimum divisor
    wb_write(4'h8, 32'd2, 4'hF, e);
    wb_write(4'h0, 32'h55, 4'hF, e);
    wb_write(4'h0, 32'h0F, 4'hF, e);
    wb_write(4'h0, 32'hF0, 4'hF, e);
    for (int i = 0; i < 4; i++) read_status_model("three_status");
    wait_drain(300);
    chk("three_gap1", mon_start_log[$] - mon_start_log[$-1], 32'd20);
    chk("three_gap2", mon_start_log[$-1] - mon_start_log[$-2], 32'd20);

    // overflow
    base_frames = frames_seen;
    wb_write(4'h8, 32'd100, 4'hF, e);
    for (int i = 0; i < 10; i++) wb_write(4'h0, $urandom_range(0, 255), 4'hF, e);
    wb_read(4'h4, rd, e);
    chk("ovf_status_model", rd, exp_status(e));
    chk("ovf_set", {31'd0, rd[3]}, 32'd1);
    chk("ovf_count", {28'd0, rd[7:4]}, 32'd8);
    wb_write(4'h4, 32'h8, 4'hF, e);
    wb_read(4'h4, rd, e);
    chk("ovf_cleared", {31'd0, rd[3]}, 32'd0);
    wait_drain(12000);
    chk("ovf_frames", frames_seen - base_frames, 32'd9);

    // divisor change mid-frame
    wb_write(4'h8, 32'd8, 4'hF, e);
    wb_write(4'h0, 32'h81, 4'hF, e);
    repeat (25) @(posedge wb_clk_i);
    wb_write(4'h8, 32'd3, 4'hF, e);
    wb_write(4'h0, 32'h81, 4'hF, e);
    wait_drain(300);
    chk("divchg_old", mon_div_log[$-1], 32'd8);
    chk("divchg_new", mon_div_log[$], 32'd3);

    // random traffic
    for (int it = 0; it < 6; it++) begin
      wb_write(4'h8, $urandom_range(0, 5), 4'hF, e);
      for (int k = 0; k < int'($urandom_range(1, 5)); k++) begin
        wb_write(4'h0, $urandom_range(0, 255), 4'hF, e);
        repeat ($urandom_range(0, 6)) @(posedge wb_clk_i);
      end
      read_status_model("rand_status");
      wait_drain(2000);
    end

    // interrupt on drain
    wb_write(4'h8, 32'd2, 4'hF, e);
    wb_write(4'hC, 32'd1, 4'hF, e);
    repeat (3) @(posedge wb_clk_i);
    wb_write(4'h0, 32'h3C, 4'hF, e);
    seen0 = 1'b0;
    rise = 0;
    for (int i = 0; i < 100; i++) begin
      if (irq_o === 1'b0) seen0 = 1'b1;
      else if (seen0 && irq_o === 1'b1) begin
        rise = cyc_cnt;
        break;
      end
      @(posedge wb_clk_i); #1;
    end
    chk("irq_rise_edge", rise, e + 22);
    wait_drain(200);

    // reset during a frame
    base_frames = frames_seen;
    wb_write(4'h0, 32'hC3, 4'hF, e2);
    repeat (8) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    chk("midrst_tx", {31'd0, uart_tx_o}, 32'd1);
    chk("midrst_irq", {31'd0, irq_o}, 32'd0);
    wb_rst_i = 1'b0;
    wb_read(4'h4, rd, e); chk("midrst_status", rd, 32'h4);
    wb_read(4'hC, rd, e); chk("midrst_ctrl", rd, 32'd0);
    repeat (60) @(posedge wb_clk_i);
    #1;
    chk("midrst_no_frame", frames_seen - base_frames, 32'd0);
    chk("midrst_tx_idle", {31'd0, uart_tx_o}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
